// File: rtl/hazard_scoreboard_if.sv
// D-stage register-usage bundle and hazard controls exchanged with the scoreboard.
// master = decoder side (drives instruction info), slave = hazard_scoreboard.
interface hazard_scoreboard_if #(
  parameter int AW = 5,
  parameter int TW = 3,
  parameter int FW = 2
);
  logic          d_valid;
  logic [AW-1:0] d_a1;
  logic [AW-1:0] d_a2;
  logic [TW-1:0] d_tuse1;
  logic [TW-1:0] d_tuse2;
  logic [AW-1:0] d_a3;
  logic          d_we;
  logic [TW-1:0] d_tnew;
  logic          d_md_start;
  logic          d_md_div;
  logic          d_md_use;
  logic          stall;
  logic [FW-1:0] fwd1;
  logic [FW-1:0] fwd2;
  logic          md_busy;

  modport master (
    output d_valid, d_a1, d_a2, d_tuse1, d_tuse2, d_a3, d_we, d_tnew,
           d_md_start, d_md_div, d_md_use,
    input  stall, fwd1, fwd2, md_busy
  );

  modport slave (
    input  d_valid, d_a1, d_a2, d_tuse1, d_tuse2, d_a3, d_we, d_tnew,
           d_md_start, d_md_div, d_md_use,
    output stall, fwd1, fwd2, md_busy
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Shift scoreboard of in-flight register writes: D-stage stall, forward selects, MDU interlock.
// Optional macro HAZ_STALL_CNT_EN adds a saturating 32-bit stall_cnt output.
module hazard_scoreboard #(
  parameter int DEPTH   = 3,
  parameter int AW      = 5,
  parameter int TW      = 3,
  parameter int FW      = 2,
  parameter int MUL_CYC = 5,
  parameter int DIV_CYC = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  hazard_scoreboard_if.slave   hz
`ifdef HAZ_STALL_CNT_EN
  ,
  output logic [31:0]          stall_cnt
`endif
);
  localparam int CW = $clog2(DIV_CYC + 1);
  localparam logic [TW-1:0] NOT_USED = '1;

  typedef struct packed {
    logic          v;
    logic [AW-1:0] a3;
    logic [TW-1:0] tnew;
  } ent_t;

  ent_t          sb [DEPTH];
  logic [CW-1:0] md_cnt;

  logic [1:0][AW-1:0] src_a;
  logic [1:0][TW-1:0] src_tu;
  logic [1:0][FW-1:0] src_fwd;
  logic [1:0]         src_stall;
  logic               md_busy_raw;
  logic               stall_raw;
  logic               accept;

  assign src_a  = {hz.d_a2, hz.d_a1};
  assign src_tu = {hz.d_tuse2, hz.d_tuse1};

  // Scan oldest to youngest so the lowest-index match overwrites older ones.
  for (genvar s = 0; s < 2; s++) begin : g_src
    logic [FW-1:0] fsel;
    logic [TW-1:0] mt;
    logic          hit;

    always_comb begin
      fsel = '0;
      mt   = '0;
      hit  = 1'b0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
        if (sb[i].v && (sb[i].a3 == src_a[s])) begin
          fsel = FW'(i + 1);
          mt   = sb[i].tnew;
          hit  = 1'b1;
        end
      end
    end

    assign src_fwd[s]   = fsel;
    assign src_stall[s] = hit && (src_a[s] != '0) && (src_tu[s] != NOT_USED) &&
                          (mt > src_tu[s]);
  end

  assign md_busy_raw = (md_cnt != '0);
  assign stall_raw   = hz.d_valid & ((|src_stall) | (hz.d_md_use & md_busy_raw));

  assign hz.stall   = ~reset & stall_raw;
  assign hz.md_busy = ~reset & md_busy_raw;
  assign hz.fwd1    = reset ? '0 : src_fwd[0];
  assign hz.fwd2    = reset ? '0 : src_fwd[1];

  assign accept = hz.d_valid & ~hz.stall;

  // The shift never freezes; a stall only turns entry 0 into a bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) sb[i] <= '0;
      md_cnt <= '0;
    end else begin
      if (accept) begin
        sb[0].v    <= hz.d_we & (hz.d_a3 != '0);
        sb[0].a3   <= hz.d_a3;
        sb[0].tnew <= hz.d_tnew;
      end else begin
        sb[0] <= '0;
      end
      for (int i = 1; i < DEPTH; i++) begin
        sb[i].v    <= sb[i-1].v;
        sb[i].a3   <= sb[i-1].a3;
        sb[i].tnew <= (sb[i-1].tnew == '0) ? '0 : sb[i-1].tnew - 1'b1;
      end

      if (accept && hz.d_md_start)
        md_cnt <= hz.d_md_div ? CW'(DIV_CYC) : CW'(MUL_CYC);
      else if (md_busy_raw)
        md_cnt <= md_cnt - 1'b1;
    end
  end

`ifdef HAZ_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (reset)
      stall_cnt <= '0;
    else if (hz.stall && (stall_cnt != 32'hFFFF_FFFF))
      stall_cnt <= stall_cnt + 32'd1;
  end
`endif
endmodule
